// File: rtl/instr_loader.sv
// instr_loader: streams a byte-encoded program into the writable instruction
// memory. Bytes arrive over rx_valid/rx_ready. A 16-bit word count comes first,
// then LO/HI byte pairs, and each pair becomes one write at the next address
// starting from 0. busy holds the core off while a session is in progress.
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailing CHK
// byte. CHK must equal the XOR of every earlier byte in the stream, including
// the count bytes.
module instr_loader #(
  parameter int A = 10,  // instruction address width, depth = 2**A
  parameter int W = 9    // instruction width, 9..16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         wr_en,
  output logic [A-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_LO = 3'd1,
    S_HDR_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_DAT_HI = 3'd4,
    S_CHK    = 3'd5
  } state_e;

  // Where the stream goes once the data bytes have been consumed.
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_e S_FIN = S_CHK;
`else
  localparam state_e S_FIN = S_IDLE;
`endif

  localparam logic [31:0] DEPTH   = 32'd1 << A;
  localparam logic [A:0]  CNT_ONE = (A+1)'(1);

  state_e         state_q, state_d;
  logic [7:0]     cnt_lo_q, cnt_lo_d;  // CNT_LO held until CNT_HI arrives
  logic [A:0]     n_q, n_d;            // word count for this session
  logic [A:0]     cnt_q, cnt_d;        // words written so far = next address
  logic [7:0]     lo_q, lo_d;          // LO byte of the word being assembled
  logic           wr_en_q, wr_en_d;
  logic [A-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;
  logic           done_q, done_d;
  logic           error_q, error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]     xor_q, xor_d;        // running XOR of every accepted byte
`endif

  logic        xfer;
  logic [15:0] hdr_n;
  logic        hdr_over;
  logic        hdr_zero;
  logic [A:0]  cnt_inc;
  logic        last_word;

  assign xfer      = rx_valid && rx_ready;
  assign hdr_n     = {rx_data, cnt_lo_q};
  // The count is bounded here, so the address counter below never wraps.
  assign hdr_over  = {16'd0, hdr_n} > DEPTH;
  assign hdr_zero  = (hdr_n == 16'd0);
  assign cnt_inc   = cnt_q + CNT_ONE;
  assign last_word = (cnt_inc == n_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; every non-idle state advances only on an accepted byte.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_HDR_LO;
      S_HDR_LO: if (xfer) state_d = S_HDR_HI;
      S_HDR_HI: begin
        if (xfer) begin
          if (hdr_over)      state_d = S_IDLE;
          else if (hdr_zero) state_d = S_FIN;
          else               state_d = S_DAT_LO;
        end
      end
      S_DAT_LO: if (xfer) state_d = S_DAT_HI;
      S_DAT_HI: if (xfer) state_d = last_word ? S_FIN : S_DAT_LO;
      S_CHK:    if (xfer) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: ready and busy come from the state alone, never from rx_valid.
  always_comb begin
    rx_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_HDR_LO, S_HDR_HI, S_DAT_LO, S_DAT_HI, S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Datapath next values: header capture, word assembly, write strobe, status.
  always_comb begin
    cnt_lo_d  = cnt_lo_q;
    n_d       = n_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = error_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
    if (xfer) xor_d = xor_q ^ rx_data;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          cnt_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d   = 8'd0;
`endif
        end
      end
      S_HDR_LO: begin
        if (xfer) cnt_lo_d = rx_data;
      end
      S_HDR_HI: begin
        if (xfer) begin
          n_d = (A+1)'(hdr_n);
          if (hdr_over) error_d = 1'b1;
`ifndef INSTR_LOADER_CHECKSUM_EN
          else if (hdr_zero) done_d = 1'b1;
`endif
        end
      end
      S_DAT_LO: begin
        if (xfer) lo_d = rx_data;
      end
      S_DAT_HI: begin
        if (xfer) begin
          // HI bits above the instruction width are dropped.
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[A-1:0];
          wr_data_d = {rx_data[W-9:0], lo_q};
          cnt_d     = cnt_inc;
`ifndef INSTR_LOADER_CHECKSUM_EN
          if (last_word) done_d = 1'b1;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHK: begin
        // The writes already happened, so a mismatch can only be flagged.
        if (xfer) begin
          if (rx_data == xor_q) done_d  = 1'b1;
          else                  error_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers; reset returns every output to 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_lo_q  <= 8'd0;
      n_q       <= '0;
      cnt_q     <= '0;
      lo_q      <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q     <= 8'd0;
`endif
    end else begin
      cnt_lo_q  <= cnt_lo_d;
      n_q       <= n_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a write monitor plus hand-computed vectors.
module tb_instr_loader;
  localparam int A = 10;
  localparam int W = 9;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam int DONE_WR = 0;  // done follows the CHK byte, not the last write
`else
  localparam int DONE_WR = 1;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   rx_data = 8'd0;
  logic         rx_valid = 1'b0;
  logic         rx_ready, wr_en, busy, done, error;
  logic [A-1:0] wr_addr;
  logic [W-1:0] wr_data;

  always #5 clk = ~clk;

  instr_loader #(.A(A), .W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Write/pulse monitor sampled on the falling edge.
  int           nw, ndone, consec, both, done_wr, rdy_idle, gap_viol;
  bit           prev_wr;
  logic [A-1:0] wa [2048];
  logic [W-1:0] wd [2048];

  always @(negedge clk) begin
    if (wr_en) begin
      if (nw < 2048) begin
        wa[nw] = wr_addr;
        wd[nw] = wr_data;
      end
      nw++;
      if (prev_wr) consec++;
    end
    prev_wr = wr_en;
    if (done) ndone++;
    if (done && error) both++;
    if (done && wr_en) done_wr++;
    if (!busy && rx_ready) rdy_idle++;
  end

  task automatic clear_mon();
    nw = 0; ndone = 0; consec = 0; both = 0; done_wr = 0; rdy_idle = 0; gap_viol = 0;
  endtask

  logic [7:0] stream [$];

  task automatic add_chk();
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'd0;
    foreach (stream[i]) x ^= stream[i];
    stream.push_back(x);
`endif
  endtask

  // All tasks start and end 1ns after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_timeout", rx_ready, 1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (gap) begin
      rx_data = 8'hEE;
      @(negedge clk);
      if (busy && !rx_ready) gap_viol++;
      @(posedge clk); #1;
    end
  endtask

  task automatic send_stream(input bit gap);
    foreach (stream[i]) send_byte(stream[i], gap);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("idle_timeout", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_basic(input string p);
    chk({p, "_nw"}, nw, 3);
    chk({p, "_a0"}, wa[0], 0);
    chk({p, "_d0"}, wd[0], 9'h001);
    chk({p, "_a1"}, wa[1], 1);
    chk({p, "_d1"}, wd[1], 9'h1FF);
    chk({p, "_a2"}, wa[2], 2);
    chk({p, "_d2"}, wd[2], 9'h0A5);
    chk({p, "_done"}, ndone, 1);
    chk({p, "_err"}, error, 0);
    chk({p, "_consec"}, consec, 0);
    chk({p, "_done_wr"}, done_wr, DONE_WR);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_rdy"}, rx_ready, 0);
    chk({p, "_rdy_idle"}, rdy_idle, 0);
  endtask

  task automatic load_basic();
    stream = '{8'h03, 8'h00, 8'h01, 8'h00, 8'hFF, 8'h01, 8'hA5, 8'h00};
    add_chk();
  endtask

  initial begin
    int bad;
    clear_mon();
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rdy", rx_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic load with rx_valid held high
    clear_mon();
    pulse_start();
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_rdy", rx_ready, 1);
    @(posedge clk); #1;
    load_basic();
    send_stream(1'b0);
    wait_idle();
    check_basic("basic");

    // Same stream with idle cycles between bytes
    clear_mon();
    pulse_start();
    load_basic();
    send_stream(1'b1);
    wait_idle();
    check_basic("gaps");
    chk("gaps_rdy_vs_valid", gap_viol, 0);

    // start pulsed mid-session is ignored
    clear_mon();
    pulse_start();
    load_basic();
    for (int i = 0; i < 5; i++) send_byte(stream[i], 1'b0);
    pulse_start();
    for (int i = 5; i < stream.size(); i++) send_byte(stream[i], 1'b0);
    wait_idle();
    check_basic("ign_start");

    // Empty load
    clear_mon();
    pulse_start();
    stream = '{8'h00, 8'h00};
    add_chk();
    send_stream(1'b0);
    wait_idle();
    chk("empty_nw", nw, 0);
    chk("empty_done", ndone, 1);
    chk("empty_err", error, 0);

    // Overflow count 1025
    clear_mon();
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    @(negedge clk);
    chk("ovf_err", error, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_rdy", rx_ready, 0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_nw", nw, 0);
    chk("ovf_done", ndone, 0);
    chk("ovf_err_sticky", error, 1);
    pulse_start();
    @(negedge clk);
    chk("ovf_clear", error, 0);
    chk("ovf_restart_busy", busy, 1);
    @(posedge clk); #1;
    stream = '{8'h00, 8'h00};
    add_chk();
    send_stream(1'b0);
    wait_idle();
    chk("ovf_restart_done", ndone, 1);

    // Full depth: N = 1024, HI upper bits set to junk
    clear_mon();
    pulse_start();
    stream = '{8'h00, 8'h04};
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] iv;
      iv = i[9:0];
      stream.push_back(iv[7:0]);
      stream.push_back(8'hA0 | {7'd0, iv[8]});
    end
    add_chk();
    send_stream(1'b0);
    wait_idle();
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] iv;
      iv = i[9:0];
      if (wa[i] !== iv || wd[i] !== iv[8:0]) bad++;
    end
    chk("full_nw", nw, 1024);
    chk("full_last_addr", wa[1023], 10'h3FF);
    chk("full_bad", bad, 0);
    chk("full_done", ndone, 1);
    chk("full_err", error, 0);
    chk("full_consec", consec, 0);

    // Reset after 2 words of a 5-word load
    clear_mon();
    pulse_start();
    stream = '{8'h05, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01};
    send_stream(1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_rdy", rx_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_nw", nw, 2);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    pulse_start();
    stream = '{8'h01, 8'h00, 8'h33, 8'h01};
    add_chk();
    send_stream(1'b0);
    wait_idle();
    chk("reload_nw", nw, 1);
    chk("reload_a0", wa[0], 0);
    chk("reload_d0", wd[0], 9'h133);
    chk("reload_done", ndone, 1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum match
    clear_mon();
    pulse_start();
    stream = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'hFF};
    send_stream(1'b0);
    wait_idle();
    chk("cs_ok_nw", nw, 1);
    chk("cs_ok_d0", wd[0], 9'h1FF);
    chk("cs_ok_a0", wa[0], 0);
    chk("cs_ok_done", ndone, 1);
    chk("cs_ok_err", error, 0);

    // Checksum mismatch
    clear_mon();
    pulse_start();
    stream = '{8'h01, 8'h00, 8'hFF, 8'h01, 8'h00};
    send_stream(1'b0);
    wait_idle();
    chk("cs_bad_nw", nw, 1);
    chk("cs_bad_d0", wd[0], 9'h1FF);
    chk("cs_bad_done", ndone, 0);
    chk("cs_bad_err", error, 1);
`endif

    chk("never_done_and_error", both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
